// File: rtl/tow_match_ctrl.sv
// Best-of-N match sequencer for the tug-of-war game: serve countdown, play gating,
// round tally, timed pause between rounds and match winner.
module tow_match_ctrl #(
    parameter int WINS_TO_MATCH = 3,
    parameter int TICK_DIV      = 4,
    parameter int SERVE_TICKS   = 3,
    parameter int HOLD_TICKS    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       win1,
    input  logic       win2,
    output logic       round_reset,
    output logic       play_en,
    output logic [1:0] countdown,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       match_over,
    output logic [1:0] winner
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);
    localparam logic [3:0]    WINS       = 4'(WINS_TO_MATCH);
    localparam logic [1:0]    SERVE_LOAD = 2'(SERVE_TICKS);

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        PLAY,
        ROUND_END,
        MATCH_OVER
    } state_t;

    state_t          state_reg, state_next;
    logic [TW-1:0]   tick_cnt_reg, tick_cnt_next;
    logic [HW-1:0]   hold_cnt_reg, hold_cnt_next;
    logic [1:0]      countdown_reg, countdown_next;
    logic [3:0]      score1_reg, score1_next;
    logic [3:0]      score2_reg, score2_next;
    logic [1:0]      winner_reg, winner_next;
    logic            round_reset_reg, round_reset_next;
    logic            start_d_reg;
    logic            start_edge;
    logic            timed_state;
    logic            tick;

    // start_d powers up high so a start held through reset release is not an edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            tick_cnt_reg    <= '0;
            hold_cnt_reg    <= '0;
            countdown_reg   <= '0;
            score1_reg      <= '0;
            score2_reg      <= '0;
            winner_reg      <= '0;
            round_reset_reg <= 1'b0;
            start_d_reg     <= 1'b1;
        end else begin
            state_reg       <= state_next;
            tick_cnt_reg    <= tick_cnt_next;
            hold_cnt_reg    <= hold_cnt_next;
            countdown_reg   <= countdown_next;
            score1_reg      <= score1_next;
            score2_reg      <= score2_next;
            winner_reg      <= winner_next;
            round_reset_reg <= round_reset_next;
            start_d_reg     <= start;
        end
    end

    assign start_edge  = start & ~start_d_reg;
    assign timed_state = (state_reg == SERVE) || (state_reg == ROUND_END);
    assign tick        = timed_state && (tick_cnt_reg == TICK_LAST);

    always_comb begin
        state_next       = state_reg;
        hold_cnt_next    = hold_cnt_reg;
        countdown_next   = countdown_reg;
        score1_next      = score1_reg;
        score2_next      = score2_reg;
        winner_next      = winner_reg;
        round_reset_next = 1'b0;
        // prescaler only runs while a timed state is active, so every entry sees it at 0
        if (timed_state) begin
            tick_cnt_next = tick ? '0 : tick_cnt_reg + TW'(1);
        end else begin
            tick_cnt_next = '0;
        end

        unique case (state_reg)
            IDLE, MATCH_OVER: begin
                if (start_edge) begin
                    state_next       = SERVE;
                    score1_next      = '0;
                    score2_next      = '0;
                    winner_next      = '0;
                    countdown_next   = SERVE_LOAD;
                    round_reset_next = 1'b1;
                    tick_cnt_next    = '0;
                end
            end
            SERVE: begin
                if (tick) begin
                    countdown_next = countdown_reg - 2'd1;
                    if (countdown_reg == 2'd1) begin
                        state_next = PLAY;
                    end
                end
            end
            PLAY: begin
                if (win1 || win2) begin
                    state_next    = ROUND_END;
                    hold_cnt_next = '0;
                    tick_cnt_next = '0;
                end
                if (win1 && !win2) begin
                    score1_next = score1_reg + 4'd1;
                    if (score1_reg + 4'd1 == WINS) begin
                        state_next  = MATCH_OVER;
                        winner_next = 2'b01;
                    end
                end else if (win2 && !win1) begin
                    score2_next = score2_reg + 4'd1;
                    if (score2_reg + 4'd1 == WINS) begin
                        state_next  = MATCH_OVER;
                        winner_next = 2'b10;
                    end
                end
            end
            ROUND_END: begin
                if (tick) begin
                    if (hold_cnt_reg == HOLD_LAST) begin
                        state_next       = SERVE;
                        countdown_next   = SERVE_LOAD;
                        round_reset_next = 1'b1;
                        tick_cnt_next    = '0;
                        hold_cnt_next    = '0;
                    end else begin
                        hold_cnt_next = hold_cnt_reg + HW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign round_reset = round_reset_reg;
    assign play_en     = (state_reg == PLAY);
    assign countdown   = countdown_reg;
    assign score1      = score1_reg;
    assign score2      = score2_reg;
    assign match_over  = (state_reg == MATCH_OVER);
    assign winner      = winner_reg;

endmodule

// File: tb/tb_tow_match_ctrl.sv
// Directed and randomized checks of tow_match_ctrl against an elapsed-time reference model.
module tb_tow_match_ctrl;

    localparam int WINS_TO_MATCH = 3;
    localparam int TICK_DIV      = 4;
    localparam int SERVE_TICKS   = 3;
    localparam int HOLD_TICKS    = 2;

    localparam int P_IDLE  = 0;
    localparam int P_SERVE = 1;
    localparam int P_PLAY  = 2;
    localparam int P_HOLD  = 3;
    localparam int P_OVER  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       win1;
    logic       win2;
    logic       round_reset;
    logic       play_en;
    logic [1:0] countdown;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       match_over;
    logic [1:0] winner;

    int total = 0;
    int bad   = 0;

    // reference model: phase plus cycles elapsed since entering it
    int m_phase;
    int m_elapsed;
    int m_s1;
    int m_s2;
    int m_win;
    bit m_rr;
    bit m_sd;

    tow_match_ctrl #(
        .WINS_TO_MATCH(WINS_TO_MATCH),
        .TICK_DIV     (TICK_DIV),
        .SERVE_TICKS  (SERVE_TICKS),
        .HOLD_TICKS   (HOLD_TICKS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .win1       (win1),
        .win2       (win2),
        .round_reset(round_reset),
        .play_en    (play_en),
        .countdown  (countdown),
        .score1     (score1),
        .score2     (score2),
        .match_over (match_over),
        .winner     (winner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase   = P_IDLE;
        m_elapsed = 0;
        m_s1      = 0;
        m_s2      = 0;
        m_win     = 0;
        m_rr      = 0;
        m_sd      = 1;
    endtask

    task automatic model_step(input bit s, input bit w1, input bit w2);
        if (!reset) begin
            model_reset();
        end else begin
            m_rr = 0;
            case (m_phase)
                P_IDLE, P_OVER: begin
                    if (s && !m_sd) begin
                        m_phase = P_SERVE; m_elapsed = 0;
                        m_s1 = 0; m_s2 = 0; m_win = 0; m_rr = 1;
                    end
                end
                P_SERVE: begin
                    if (m_elapsed == TICK_DIV * SERVE_TICKS - 1) begin
                        m_phase = P_PLAY; m_elapsed = 0;
                    end else m_elapsed++;
                end
                P_PLAY: begin
                    if (w1 && w2) begin
                        m_phase = P_HOLD; m_elapsed = 0;
                    end else if (w1) begin
                        m_s1++; m_elapsed = 0;
                        if (m_s1 == WINS_TO_MATCH) begin m_phase = P_OVER; m_win = 1; end
                        else m_phase = P_HOLD;
                    end else if (w2) begin
                        m_s2++; m_elapsed = 0;
                        if (m_s2 == WINS_TO_MATCH) begin m_phase = P_OVER; m_win = 2; end
                        else m_phase = P_HOLD;
                    end
                end
                default: begin
                    if (m_elapsed == TICK_DIV * HOLD_TICKS - 1) begin
                        m_phase = P_SERVE; m_elapsed = 0; m_rr = 1;
                    end else m_elapsed++;
                end
            endcase
            m_sd = s;
        end
    endtask

    task automatic check_all();
        int exp_cd;
        exp_cd = (m_phase == P_SERVE) ? SERVE_TICKS - m_elapsed / TICK_DIV : 0;
        chk("round_reset", round_reset, m_rr);
        chk("play_en", play_en, m_phase == P_PLAY);
        chk("countdown", countdown, exp_cd);
        chk("score1", score1, m_s1);
        chk("score2", score2, m_s2);
        chk("match_over", match_over, m_phase == P_OVER);
        chk("winner", winner, m_win);
    endtask

    // inputs change on the falling edge; outputs are checked on the next falling edge
    task automatic step(input bit s, input bit w1, input bit w2);
        start = s; win1 = w1; win2 = w2;
        @(posedge clk);
        model_step(s, w1, w2);
        @(negedge clk);
        check_all();
        $display("step t=%0t start=%0b win=%0b%0b rr=%0b play=%0b cd=%0d s=%0d/%0d over=%0b win=%0d",
                 $time, s, w1, w2, round_reset, play_en, countdown, score1, score2,
                 match_over, winner);
    endtask

    task automatic wait_phase(input int target);
        for (int i = 0; i < 200 && m_phase != target; i++) step(0, 0, 0);
        if (m_phase != target) chk("phase_timeout", m_phase, target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; win1 = 1'b0; win2 = 1'b0;
        model_reset();
        @(negedge clk);
        check_all();
        reset = 1'b1;

        // 1: serve countdown and play opening
        step(0, 0, 0);
        step(1, 0, 0);
        chk("t1_round_reset", round_reset, 1);
        chk("t1_countdown", countdown, 3);
        for (int i = 1; i <= 12; i++) begin
            step(0, 0, 0);
            if (i == 4) chk("t1_cd2", countdown, 2);
            if (i == 8) chk("t1_cd1", countdown, 1);
            chk("t1_play_en", play_en, i == 12);
        end

        // 2: player round win, then pause back to serve
        step(0, 1, 0);
        chk("t2_score1", score1, 1);
        chk("t2_play_off", play_en, 0);
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 0);
            chk("t2_round_reset", round_reset, i == 8);
        end
        chk("t2_countdown", countdown, 3);

        // 3: tie replays the round
        wait_phase(P_PLAY);
        step(0, 1, 1);
        chk("t3_score1", score1, 1);
        chk("t3_score2", score2, 0);

        // 4: wins outside PLAY are ignored
        step(0, 0, 1);
        wait_phase(P_SERVE);
        step(0, 0, 1);
        step(0, 0, 1);
        chk("t4_score2", score2, 0);

        // 5: cyber side takes the match, then a restart
        for (int r = 0; r < 3; r++) begin
            wait_phase(P_PLAY);
            step(0, 0, 1);
        end
        chk("t5_score2", score2, 3);
        chk("t5_match_over", match_over, 1);
        chk("t5_winner", winner, 2);
        for (int i = 0; i < 20; i++) step(0, 0, 0);
        step(1, 0, 0);
        chk("t5_restart_s2", score2, 0);
        chk("t5_restart_win", winner, 0);
        chk("t5_restart_rr", round_reset, 1);

        // 6: asynchronous abort mid-play, start held through release
        wait_phase(P_PLAY);
        step(0, 0, 0);
        #1 reset = 1'b0;
        #1;
        chk("t6_play_en", play_en, 0);
        chk("t6_score1", score1, 0);
        chk("t6_winner", winner, 0);
        chk("t6_countdown", countdown, 0);
        model_reset();
        @(negedge clk);
        step(1, 0, 0);
        step(1, 0, 0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        chk("t6_idle_rr", round_reset, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        chk("t6_serve_rr", round_reset, 1);
        chk("t6_serve_cd", countdown, 3);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 29) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 4) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
